// File: rtl/cac_uart_pkg.sv
// Shared UART definitions: FSM state encoding, baud divider derivation and
// default line settings, common to the receiver and the matching transmitter.
package cac_uart_pkg;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_START,
      ST_DATA,
      ST_STOP
   } uart_state_t;

   localparam int DEF_BAUDRATE = 115200;
   localparam int DEF_BITLEN   = 8;

   // Clock cycles per bit, rounded to nearest.
   function automatic int calc_div(input int clk_freq, input int baudrate);
      return (clk_freq + baudrate / 2) / baudrate;
   endfunction

   function automatic int calc_half(input int div);
      return div / 2;
   endfunction

endpackage

// File: rtl/cac_sync2.sv
// Two-flop synchronizer for a single asynchronous bit; RST_VAL sets the
// value both flops take in reset.
module cac_sync2 #(
   parameter logic RST_VAL = 1'b1
) (
   input  logic clk,
   input  logic rst,
   input  logic d,
   output logic q
);

   logic meta_p0;

   always_ff @(posedge clk) begin
      if (rst) begin
         meta_p0 <= RST_VAL;
         q       <= RST_VAL;
      end else begin
         meta_p0 <= d;
         q       <= meta_p0;
      end
   end

endmodule

// File: rtl/cac_uart_rx.sv
// UART receiver: 8N1-style framing with configurable word length, ready/valid
// output, framing/overrun pulses and saturating error counters.
module cac_uart_rx
   import cac_uart_pkg::*;
#(
   parameter int CLK_FREQ     = 10_000_000,
   parameter int BAUDRATE     = DEF_BAUDRATE,
   parameter int BITLEN       = DEF_BITLEN,
   parameter int ERRCNT_WIDTH = 8
) (
   input  logic                    clk_cac,
   input  logic                    rst,
   input  logic                    uart_rx,
   output logic [BITLEN-1:0]       rx_data,
   output logic                    rx_valid,
   input  logic                    rx_ready,
   output logic                    frame_err,
   output logic                    overrun_err,
   output logic [ERRCNT_WIDTH-1:0] frame_err_cnt,
   output logic [ERRCNT_WIDTH-1:0] overrun_cnt,
   output logic                    rx_busy
);

   localparam int DIV   = calc_div(CLK_FREQ, BAUDRATE);
   localparam int HALF  = calc_half(DIV);
   localparam int CNT_W = $clog2(DIV);
   localparam int BIT_W = $clog2(BITLEN + 1);

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV - 1);
   localparam logic [CNT_W-1:0] CNT_MID  = CNT_W'(HALF - 1);
   localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(BITLEN - 1);

   generate
      if (DIV < 4) begin : g_div_check
         $error("cac_uart_rx: CLK_FREQ/BAUDRATE must give at least 4 cycles per bit");
      end
      if (BITLEN < 5 || BITLEN > 9) begin : g_bitlen_check
         $error("cac_uart_rx: BITLEN must be in 5..9");
      end
   endgenerate

   function automatic logic [ERRCNT_WIDTH-1:0] sat_inc(input logic [ERRCNT_WIDTH-1:0] v);
      return (&v) ? v : v + ERRCNT_WIDTH'(1);
   endfunction

   uart_state_t       state;
   logic [CNT_W-1:0]  cnt;
   logic [BIT_W-1:0]  bit_idx;
   logic [BITLEN-1:0] shreg;
   logic              line_s;
   logic              line_prev;

   cac_sync2 #(.RST_VAL(1'b1)) u_sync (
      .clk (clk_cac),
      .rst (rst),
      .d   (uart_rx),
      .q   (line_s)
   );

   assign rx_busy = (state != ST_IDLE);

   always_ff @(posedge clk_cac) begin
      if (rst) begin
         state         <= ST_IDLE;
         cnt           <= '0;
         bit_idx       <= '0;
         shreg         <= '0;
         line_prev     <= 1'b1;
         rx_data       <= '0;
         rx_valid      <= 1'b0;
         frame_err     <= 1'b0;
         overrun_err   <= 1'b0;
         frame_err_cnt <= '0;
         overrun_cnt   <= '0;
      end else begin
         line_prev   <= line_s;
         frame_err   <= 1'b0;
         overrun_err <= 1'b0;
         // A completing word in STOP below overrides this clear.
         if (rx_valid && rx_ready) rx_valid <= 1'b0;

         case (state)
            ST_IDLE: begin
               cnt     <= '0;
               bit_idx <= '0;
               if (line_prev && !line_s) state <= ST_START;
            end
            ST_START: begin
               if (cnt == CNT_MID) begin
                  cnt   <= '0;
                  state <= line_s ? ST_IDLE : ST_DATA;
               end else begin
                  cnt <= cnt + CNT_W'(1);
               end
            end
            ST_DATA: begin
               if (cnt == CNT_LAST) begin
                  cnt     <= '0;
                  shreg   <= {line_s, shreg[BITLEN-1:1]};
                  bit_idx <= bit_idx + BIT_W'(1);
                  if (bit_idx == BIT_LAST) state <= ST_STOP;
               end else begin
                  cnt <= cnt + CNT_W'(1);
               end
            end
            ST_STOP: begin
               if (cnt == CNT_LAST) begin
                  cnt   <= '0;
                  state <= ST_IDLE;
                  if (!line_s) begin
                     frame_err     <= 1'b1;
                     frame_err_cnt <= sat_inc(frame_err_cnt);
                  end else if (!rx_valid || rx_ready) begin
                     rx_data  <= shreg;
                     rx_valid <= 1'b1;
                  end else begin
                     overrun_err <= 1'b1;
                     overrun_cnt <= sat_inc(overrun_cnt);
                  end
               end else begin
                  cnt <= cnt + CNT_W'(1);
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_cac_uart_rx.sv
// Directed bench for cac_uart_rx: one instance at 10 MHz / 115200 baud and a
// second, fast-divider instance used for counter saturation.
module tb_cac_uart_rx;

   localparam int DIV_M = 87;
   localparam int DIV_F = 8;

   logic       clk = 1'b0;
   logic       rst;

   logic       line_m, ready_m;
   logic [7:0] data_m;
   logic       valid_m, fe_m, ov_m, busy_m;
   logic [7:0] fec_m, ovc_m;

   logic       line_f, ready_f;
   logic [7:0] data_f;
   logic       valid_f, fe_f, ov_f, busy_f;
   logic [7:0] fec_f, ovc_f;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   cac_uart_rx #(
      .CLK_FREQ(10_000_000), .BAUDRATE(115200), .BITLEN(8), .ERRCNT_WIDTH(8)
   ) dut (
      .clk_cac(clk), .rst(rst), .uart_rx(line_m),
      .rx_data(data_m), .rx_valid(valid_m), .rx_ready(ready_m),
      .frame_err(fe_m), .overrun_err(ov_m),
      .frame_err_cnt(fec_m), .overrun_cnt(ovc_m), .rx_busy(busy_m)
   );

   cac_uart_rx #(
      .CLK_FREQ(80), .BAUDRATE(10), .BITLEN(8), .ERRCNT_WIDTH(8)
   ) dut_fast (
      .clk_cac(clk), .rst(rst), .uart_rx(line_f),
      .rx_data(data_f), .rx_valid(valid_f), .rx_ready(ready_f),
      .frame_err(fe_f), .overrun_err(ov_f),
      .frame_err_cnt(fec_f), .overrun_cnt(ovc_f), .rx_busy(busy_f)
   );

   // Monitor: counts pulses/valid cycles and records every handshake word.
   int         vcyc = 0, fe_n = 0, ov_n = 0, fvc = 0, ffe_n = 0, hs_n = 0;
   logic [7:0] hs_data [0:15];

   always @(negedge clk) begin
      if (valid_m) vcyc++;
      if (fe_m)    fe_n++;
      if (ov_m)    ov_n++;
      if (valid_f) fvc++;
      if (fe_f)    ffe_n++;
      if (valid_m && ready_m && hs_n < 16) begin
         hs_data[hs_n] = data_m;
         hs_n++;
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end

   logic [7:0] exp_q[$];
   int         rd_idx = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic cyc(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic set_line(input logic v, input bit fast);
      if (fast) line_f = v;
      else      line_m = v;
   endtask

   task automatic send_frame(input logic [7:0] d, input logic stop, input bit fast);
      int div;
      div = fast ? DIV_F : DIV_M;
      set_line(1'b0, fast);
      cyc(div);
      for (int i = 0; i < 8; i++) begin
         set_line(d[i], fast);
         cyc(div);
      end
      set_line(stop, fast);
      cyc(div);
      set_line(1'b1, fast);
   endtask

   task automatic check_words(input string tag);
      logic [7:0] exp;
      int         budget;
      while (exp_q.size() > 0) begin
         exp    = exp_q.pop_front();
         budget = 2000;
         while (hs_n <= rd_idx && budget > 0) begin
            @(negedge clk);
            budget--;
         end
         chk({tag, "_arrived"}, 32'(hs_n > rd_idx), 1);
         if (hs_n > rd_idx) begin
            chk({tag, "_data"}, hs_data[rd_idx], exp);
            rd_idx++;
         end
      end
   endtask

   int vc0, fe0, ov0, ffe0;

   initial begin
      rst = 1'b1; line_m = 1'b1; line_f = 1'b1; ready_m = 1'b1; ready_f = 1'b1;
      cyc(5);
      chk("rst_valid", valid_m, 0);
      chk("rst_data", data_m, 0);
      chk("rst_busy", busy_m, 0);
      chk("rst_fe", fe_m, 0);
      chk("rst_ov", ov_m, 0);
      chk("rst_fec", fec_m, 0);
      chk("rst_ovc", ovc_m, 0);
      rst = 1'b0;
      cyc(10);

      // Clean frame, consumer always ready
      vc0 = vcyc; fe0 = fe_n; ov0 = ov_n;
      exp_q.push_back(8'hA5);
      send_frame(8'hA5, 1'b1, 1'b0);
      cyc(20);
      check_words("a5");
      chk("a5_valid_cycles", vcyc - vc0, 1);
      chk("a5_fe_pulses", fe_n - fe0, 0);
      chk("a5_ov_pulses", ov_n - ov0, 0);
      chk("a5_busy", busy_m, 0);

      // Bad stop bit
      vc0 = vcyc; fe0 = fe_n;
      send_frame(8'h3C, 1'b0, 1'b0);
      cyc(20);
      chk("fe_pulses", fe_n - fe0, 1);
      chk("fe_cnt", fec_m, 1);
      chk("fe_valid_cycles", vcyc - vc0, 0);
      chk("fe_busy", busy_m, 0);

      // Back-to-back frames with consumer stalled: second word overruns
      ready_m = 1'b0;
      ov0 = ov_n;
      exp_q.push_back(8'h11);
      send_frame(8'h11, 1'b1, 1'b0);
      send_frame(8'h22, 1'b1, 1'b0);
      cyc(20);
      chk("ovr_data_held", data_m, 8'h11);
      chk("ovr_valid", valid_m, 1);
      chk("ovr_pulses", ov_n - ov0, 1);
      chk("ovr_cnt", ovc_m, 1);
      ready_m = 1'b1;
      check_words("ovr");
      cyc(2);
      chk("ovr_valid_after", valid_m, 0);

      // Short low glitch on the idle line
      vc0 = vcyc; fe0 = fe_n;
      line_m = 1'b0;
      cyc(10);
      chk("glitch_busy_high", busy_m, 1);
      cyc(10);
      line_m = 1'b1;
      cyc(100);
      chk("glitch_busy_low", busy_m, 0);
      chk("glitch_valid_cycles", vcyc - vc0, 0);
      chk("glitch_fe_pulses", fe_n - fe0, 0);
      chk("glitch_fec", fec_m, 1);

      // Reset in the middle of 0xFF, then a clean 0x5A
      vc0 = vcyc; fe0 = fe_n; ov0 = ov_n;
      line_m = 1'b0;
      cyc(DIV_M);
      line_m = 1'b1;
      cyc(4 * DIV_M + 40);
      chk("abort_busy_before", busy_m, 1);
      rst = 1'b1;
      cyc(2);
      rst = 1'b0;
      cyc(1);
      chk("abort_busy", busy_m, 0);
      chk("abort_valid", valid_m, 0);
      chk("abort_fec", fec_m, 0);
      chk("abort_ovc", ovc_m, 0);
      cyc(20);
      exp_q.push_back(8'h5A);
      send_frame(8'h5A, 1'b1, 1'b0);
      cyc(20);
      check_words("abort_5a");
      chk("abort_valid_cycles", vcyc - vc0, 1);
      chk("abort_fe_pulses", fe_n - fe0, 0);
      chk("abort_ov_pulses", ov_n - ov0, 0);
      chk("abort_fec_end", fec_m, 0);
      chk("abort_ovc_end", ovc_m, 0);

      // Framing-error counter saturation on the fast instance
      ffe0 = ffe_n;
      for (int i = 0; i < 260; i++) begin
         send_frame(8'h00, 1'b0, 1'b1);
         cyc(4);
         if (i == 99) chk("sat_cnt_100", fec_f, 100);
         if (i == 254) chk("sat_cnt_255", fec_f, 255);
      end
      cyc(10);
      chk("sat_cnt_final", fec_f, 255);
      chk("sat_pulses", ffe_n - ffe0, 260);
      chk("sat_valid_cycles", fvc, 0);
      chk("sat_ovc", ovc_f, 0);

      chk("scoreboard_empty", exp_q.size(), 0);
      chk("handshakes_total", hs_n, 3);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/cac_uart_rx.md
CAC_UART_RX -- requirements
Module: cac_uart_rx

Interface
REQ-001 Parameter CLK_FREQ, default 10_000_000, clk_cac frequency in Hz.
REQ-002 Parameter BAUDRATE, default 115200, line bit rate.
REQ-003 Parameter BITLEN, default 8, data bits per frame (5..9), LSB first, no parity, one stop bit.
REQ-004 Parameter ERRCNT_WIDTH, default 8, width of error counters.
REQ-005 clk_cac  input  1  single clock; all logic on rising edge.
REQ-006 rst  input  1  synchronous, active-high reset.
REQ-007 uart_rx  input  1  asynchronous serial line, idle high.
REQ-008 rx_data  output  BITLEN  received word, stable while rx_valid high.
REQ-009 rx_valid  output  1  word available.
REQ-010 rx_ready  input  1  consumer accepts word when rx_valid and rx_ready both high.
REQ-011 frame_err  output  1  one-cycle pulse on bad stop bit.
REQ-012 overrun_err  output  1  one-cycle pulse when a completed word is dropped.
REQ-013 frame_err_cnt, overrun_cnt  output  ERRCNT_WIDTH each  saturating error counters.
REQ-014 rx_busy  output  1  high whenever FSM is not IDLE.

Function
REQ-015 uart_rx passes a 2-flop synchronizer before any use; synchronizer latency 2 cycles.
REQ-016 DIV = round(CLK_FREQ/BAUDRATE), computed at elaboration; HALF = DIV/2 (integer division); DIV < 4 is an elaboration error.
REQ-017 FSM states IDLE, START, DATA, STOP.
REQ-018 IDLE: falling edge of synchronized line (1 then 0) -> START, baud counter loaded to 0.
REQ-019 START: at count HALF-1, sample line; low -> DATA with counter cleared; high -> IDLE (glitch rejected, no error).
REQ-020 DATA: sample each bit at count DIV-1 (mid-bit), shift in LSB first; after BITLEN samples -> STOP.
REQ-021 STOP: sample at count DIV-1; high -> word complete; low -> frame_err pulse, word discarded; either case -> IDLE same cycle.
REQ-022 In IDLE the counter is held at 0; in other states it counts 0..DIV-1 and wraps.
REQ-023 Word complete with rx_valid low: rx_data loaded, rx_valid high next cycle.
REQ-024 Word complete with rx_valid high and rx_ready low: new word dropped, rx_data unchanged, overrun_err pulse.
REQ-025 Word complete in same cycle as handshake (rx_valid and rx_ready high): handshake consumes old word, new word loaded, rx_valid stays high, no overrun.
REQ-026 Handshake without completion: rx_valid low next cycle.
REQ-027 Counters increment by 1 per error pulse, saturate at all-ones, never wrap.
REQ-028 Latency: rx_valid rises 1 cycle after the STOP sample cycle.
REQ-029 A new start edge is detected immediately in IDLE after STOP (back-to-back frames, no idle bit beyond stop required).

Reset
REQ-030 rst high: FSM IDLE, counters/shift register 0, rx_data 0, rx_valid 0, frame_err 0, overrun_err 0, both error counters 0, rx_busy 0.
REQ-031 Synchronizer flops reset to 1 (idle line) so no false start edge on release.
REQ-032 rst mid-frame aborts the frame; partial word is never presented; no error pulse.

Structure
REQ-033 Shared package cac_uart_pkg holds FSM state enum, DIV/HALF derivation function, and default BAUDRATE/BITLEN constants, reused by the matching transmitter.
REQ-034 One sub-module: cac_sync2 (2-flop synchronizer with reset value parameter).
REQ-035 Block sits between pad uart_rx and the communication_and_control command parser; no other dependencies.

Verification (CLK_FREQ=10_000_000, BAUDRATE=115200 -> DIV=87, HALF=43)
REQ-036 Send 0xA5, rx_ready held high -> rx_data=0xA5, rx_valid high exactly 1 cycle, no errors.
REQ-037 Send 0x3C with stop bit 0 -> frame_err one pulse, frame_err_cnt=1, rx_valid never rises.
REQ-038 rx_ready low, send 0x11 then 0x22 back-to-back -> rx_data=0x11 held, overrun_err pulse, overrun_cnt=1; then rx_ready high -> 0x11 consumed.
REQ-039 20-cycle low glitch on idle line -> FSM returns IDLE, no rx_valid, no errors.
REQ-040 Assert rst at bit 4 of 0xFF, release, send 0x5A -> only 0x5A delivered; counters 0.
REQ-041 Force 260 framing errors with ERRCNT_WIDTH=8 -> frame_err_cnt saturates at 255.
